// File: rtl/phase_sequencer_if.sv
// Phase sequencer bundle: enables/sync in, ring state and status out.
// master = sequencer side, slave = phase-decode / controlling side.
interface phase_sequencer_if #(
   parameter int STAGES = 8
);
   localparam int PHASE_W = $clog2(2 * STAGES);

   logic               CE;
   logic               HOLD;
   logic               SYNC;
   logic [STAGES-1:0]  S;
   logic [PHASE_W-1:0] PHASE;
   logic               WRAP;
   logic               FAULT;

   modport master (
      input  CE, HOLD, SYNC,
      output S, PHASE, WRAP, FAULT
   );

   modport slave (
      output CE, HOLD, SYNC,
      input  S, PHASE, WRAP, FAULT
   );
endinterface

// File: rtl/phase_sequencer.sv
// Johnson-ring master phase generator with sync jump and illegal-code recovery.
// Ports: CLK_n/RESET_n plain; bus.master carries CE/HOLD/SYNC in, S/PHASE/WRAP/FAULT out.
module phase_sequencer #(
   parameter int STAGES = 8
) (
   input  logic               CLK_n,
   input  logic               RESET_n,
   phase_sequencer_if.master  bus
);
   localparam int N       = STAGES;
   localparam int PHASE_W = $clog2(2 * STAGES);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] TOP = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0]       s_q;
   logic [PHASE_W-1:0] phase_q;
   logic               wrap_q;
   logic               fault_q;

   logic [N-1:0]       s_adv;
   logic [PHASE_W-1:0] phase_adv;
   logic [N-1:0]       t_cur;
   logic               legal;
   logic               f;

   // Fold the falling half onto the rising half: a legal code then
   // becomes a run of low ones, which x & (x+1) == 0 detects.
   function automatic logic [N-1:0] fold(input logic [N-1:0] x);
      return x[N-1] ? ~x : x;
   endfunction

   // Index = ones count in the rising half, N + zeros count in the falling half.
   function automatic logic [PHASE_W-1:0] phase_of(input logic [N-1:0] x);
      logic [N-1:0] t;
      int           cnt;
      t   = fold(x);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + int'(t[i]);
      end
      if (x[N-1]) begin
         cnt = cnt + N;
      end
      return PHASE_W'(cnt);
   endfunction

   always_comb begin
      t_cur = fold(s_q);
      legal = ((t_cur & (t_cur + ONE)) == '0);
   end

   // f forces the middle stages high: a SYNC in the rising half jumps
   // straight to phase N-1; at phase N-1 it is a no-op on the result.
   always_comb begin
      f = (bus.SYNC & ~s_q[N-1]) | (s_q[N-2] & ~s_q[N-1]);
      s_adv      = '0;
      s_adv[0]   = ~s_q[N-1];
      for (int i = 1; i <= N - 2; i++) begin
         s_adv[i] = s_q[i-1] | f;
      end
      s_adv[N-1] = s_q[N-2];
      phase_adv  = phase_of(s_adv);
   end

   always_ff @(posedge CLK_n or negedge RESET_n) begin
      if (!RESET_n) begin
         s_q     <= '0;
         phase_q <= '0;
         wrap_q  <= 1'b0;
         fault_q <= 1'b0;
      end else if (!bus.CE || bus.HOLD) begin
         wrap_q  <= 1'b0;
      end else if (!legal) begin
         s_q     <= '0;
         phase_q <= '0;
         fault_q <= 1'b1;
         wrap_q  <= 1'b0;
      end else begin
         s_q     <= s_adv;
         phase_q <= phase_adv;
         // Only phase 2N-1 (MSB alone) advances into phase 0.
         wrap_q  <= (s_q == TOP);
      end
   end

   assign bus.S     = s_q;
   assign bus.PHASE = phase_q;
   assign bus.WRAP  = wrap_q;
   assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: 8- and 4-stage instances, queued expectations.
// Stimulus pushes expected post-edge state; monitor pops after each posedge.
module tb_phase_sequencer;
   logic CLK_n = 1'b0;
   logic rst8_n;
   logic rst4_n;

   always #5 CLK_n = ~CLK_n;

   phase_sequencer_if #(.STAGES(8)) if8 ();
   phase_sequencer_if #(.STAGES(4)) if4 ();

   phase_sequencer #(.STAGES(8)) dut8 (
      .CLK_n   (CLK_n),
      .RESET_n (rst8_n),
      .bus     (if8)
   );

   phase_sequencer #(.STAGES(4)) dut4 (
      .CLK_n   (CLK_n),
      .RESET_n (rst4_n),
      .bus     (if4)
   );

   typedef struct {
      string name;
      int    unit;
      int    s;
      int    ph;
      int    wr;
      int    fl;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic cmp(input exp_t e, input int s, input int ph,
                      input int wr, input int fl);
      check({e.name, ".S"}, s, e.s);
      check({e.name, ".PHASE"}, ph, e.ph);
      check({e.name, ".WRAP"}, wr, e.wr);
      check({e.name, ".FAULT"}, fl, e.fl);
   endtask

   always @(posedge CLK_n) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         if (e.unit == 8)
            cmp(e, int'(if8.S), int'(if8.PHASE), int'(if8.WRAP), int'(if8.FAULT));
         else
            cmp(e, int'(if4.S), int'(if4.PHASE), int'(if4.WRAP), int'(if4.FAULT));
      end
   end

   task automatic drive(input int unit, input bit ce, input bit hold, input bit sync);
      if (unit == 8) begin
         if8.CE = ce; if8.HOLD = hold; if8.SYNC = sync;
      end else begin
         if4.CE = ce; if4.HOLD = hold; if4.SYNC = sync;
      end
   endtask

   task automatic step(input int unit, input bit ce, input bit hold, input bit sync,
                       input bit push, input string name,
                       input int s, input int ph, input int wr, input int fl);
      @(negedge CLK_n);
      drive(unit, ce, hold, sync);
      if (push)
         sb.push_back('{name: name, unit: unit, s: s, ph: ph, wr: wr, fl: fl});
   endtask

   int t8[16] = '{'h01, 'h03, 'h07, 'h0F, 'h1F, 'h3F, 'h7F, 'hFF,
                  'hFE, 'hFC, 'hF8, 'hF0, 'hE0, 'hC0, 'h80, 'h00};
   int t4[8]  = '{'h1, 'h3, 'h7, 'hF, 'hE, 'hC, 'h8, 'h0};
   int y4[7]  = '{'h7, 'hF, 'hE, 'hC, 'h8, 'h0, 'h7};
   int y4p[7] = '{3, 4, 5, 6, 7, 0, 3};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(8, 0, 0, 0);
      drive(4, 0, 0, 0);
      rst8_n = 1'b0;
      rst4_n = 1'b0;

      #2;
      check("rst.S", int'(if8.S), 0);
      check("rst.PHASE", int'(if8.PHASE), 0);
      check("rst.WRAP", int'(if8.WRAP), 0);
      check("rst.FAULT", int'(if8.FAULT), 0);
      if8.CE = 1'b1;
      #5;
      check("rst_edge.S", int'(if8.S), 0);
      rst8_n = 1'b1;

      // free run, 16 edges
      for (int i = 0; i < 16; i++)
         step(8, 1, 0, 0, 1, "run", t8[i], (i + 1) % 16, (i == 15) ? 1 : 0, 0);
      step(8, 1, 0, 0, 1, "run_w0", 'h01, 1, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h03, 2, 0, 0);

      // sync jump in rising half
      step(8, 1, 0, 1, 1, "sync_up", 'h7F, 7, 0, 0);
      step(8, 1, 0, 0, 1, "sync_nx", 'hFF, 8, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'hFE, 9, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'hFC, 10, 0, 0);

      // sync ignored in falling half
      step(8, 1, 0, 1, 1, "sync_dn", 'hF8, 11, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'hF0, 12, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'hE0, 13, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'hC0, 14, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h80, 15, 0, 0);
      step(8, 1, 0, 0, 1, "wrap2", 'h00, 0, 1, 0);
      step(8, 1, 0, 0, 1, "run", 'h01, 1, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h03, 2, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h07, 3, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h0F, 4, 0, 0);
      step(8, 1, 0, 0, 1, "run", 'h1F, 5, 0, 0);

      // clock enable low, then hold (hold beats sync)
      for (int i = 0; i < 5; i++)
         step(8, 0, 0, 0, 1, "ce0", 'h1F, 5, 0, 0);
      for (int i = 0; i < 3; i++)
         step(8, 1, 1, (i == 1) ? 1'b1 : 1'b0, 1, "hold", 'h1F, 5, 0, 0);
      step(8, 1, 0, 0, 1, "resume", 'h3F, 6, 0, 0);

      // illegal code recovery
      @(negedge CLK_n);
      force dut8.s_q = 8'h55;
      #1;
      release dut8.s_q;
      check("pre_fault.FAULT", int'(if8.FAULT), 0);
      sb.push_back('{name: "recover", unit: 8, s: 0, ph: 0, wr: 0, fl: 1});
      for (int i = 0; i < 19; i++)
         step(8, 1, 0, 0, 0, "", 0, 0, 0, 0);
      step(8, 1, 0, 0, 1, "sticky", 'h0F, 4, 0, 1);
      @(negedge CLK_n);
      drive(8, 0, 0, 0);
      rst8_n = 1'b0;
      #1;
      check("fault_rst.FAULT", int'(if8.FAULT), 0);
      check("fault_rst.S", int'(if8.S), 0);

      // 4-stage ring
      @(posedge CLK_n);
      #2;
      rst4_n = 1'b1;
      for (int i = 0; i < 8; i++)
         step(4, 1, 0, 0, 1, "r4", t4[i], (i + 1) % 8, (i == 7) ? 1 : 0, 0);
      for (int i = 0; i < 7; i++)
         step(4, 1, 0, 1, 1, "r4_sync", y4[i], y4p[i], (i == 5) ? 1 : 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'hF, 4, 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'hE, 5, 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'hC, 6, 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'h8, 7, 0, 0);
      step(4, 1, 0, 0, 1, "r4_wrap", 'h0, 0, 1, 0);
      step(4, 1, 1, 0, 1, "r4_hold0", 'h0, 0, 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'h1, 1, 0, 0);
      step(4, 1, 0, 0, 1, "r4", 'h3, 2, 0, 0);

      // asynchronous reset between edges
      @(posedge CLK_n);
      #3;
      rst4_n = 1'b0;
      #1;
      check("r4_async.S", int'(if4.S), 0);
      check("r4_async.PHASE", int'(if4.PHASE), 0);
      rst4_n = 1'b1;
      step(4, 1, 0, 0, 1, "r4_post", 'h1, 1, 0, 0);

      repeat (2) @(negedge CLK_n);
      check("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
